core_sequencer: RTL

Multi-cycle control FSM for the RV32I core. It fetches each instruction over a request/ready memory handshake, steps it through decode, execute, memory and write-back, and issues the one-cycle write strobes for the IR, PC and register file. It consumes the opcode and control flags already produced by the instruction decoder, and it counts retired instructions.

---
 rtl/core_sequencer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for the RV32I core.
// Build option: define SEQ_ILLEGAL_TRAP_EN to trap on unrecognised opcodes instead of retiring them as NOPs.
module core_sequencer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             reg_write,
    input  logic             mem_write,
    input  logic             branch_taken,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             rf_we,
    output logic             halted,
    output logic             trap,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instret
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_TRAP   = 3'd6
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             imem_req_c, dmem_req_c, dmem_we_c, ir_we_c, pc_we_c, rf_we_c;
    logic [1:0]       pc_sel_c;

    always_comb begin
        state_d    = state_q;
        imem_req_c = 1'b0;
        dmem_req_c = 1'b0;
        dmem_we_c  = 1'b0;
        ir_we_c    = 1'b0;
        pc_we_c    = 1'b0;
        rf_we_c    = 1'b0;
        pc_sel_c   = 2'd0;
        case (state_q)
            S_FETCH: begin
                imem_req_c = 1'b1;
                if (imem_ready) begin
                    ir_we_c = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEM;
                    OP_BRANCH: begin
                        pc_we_c  = 1'b1;
                        pc_sel_c = branch_taken ? 2'd1 : 2'd0;
                        state_d  = S_FETCH;
                    end
                    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_REG: state_d = S_WB;
                    OP_SYSTEM: state_d = S_HALT;
                    default: begin
`ifdef SEQ_ILLEGAL_TRAP_EN
                        state_d = S_TRAP;
`else
                        pc_we_c = 1'b1;
                        state_d = S_FETCH;
`endif
                    end
                endcase
            end
            S_MEM: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = mem_write;
                if (dmem_ready) begin
                    // Stores retire straight out of MEM; loads still need the register write.
                    if (opcode == OP_STORE) begin
                        pc_we_c = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we_c = reg_write;
                pc_we_c = 1'b1;
                if (opcode == OP_JAL) begin
                    pc_sel_c = 2'd1;
                end else if (opcode == OP_JALR) begin
                    pc_sel_c = 2'd2;
                end
                state_d = S_FETCH;
            end
            S_HALT, S_TRAP: state_d = state_q;
            default: state_d = S_FETCH;
        endcase
        instret_d = instret_q + {{(CNT_W-1){1'b0}}, pc_we_c};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    // Every output is forced low while reset is asserted, so an abandoned access leaves no strobe behind.
    assign imem_req = imem_req_c & ~rst;
    assign dmem_req = dmem_req_c & ~rst;
    assign dmem_we  = dmem_we_c & ~rst;
    assign ir_we    = ir_we_c & ~rst;
    assign pc_we    = pc_we_c & ~rst;
    assign rf_we    = rf_we_c & ~rst;
    assign pc_sel   = rst ? 2'd0 : pc_sel_c;
    assign state    = rst ? 3'd0 : state_q;
    assign instret  = rst ? '0 : instret_q;
    assign halted   = ~rst & ((state_q == S_HALT) || (state_q == S_TRAP));
`ifdef SEQ_ILLEGAL_TRAP_EN
    assign trap     = ~rst & (state_q == S_TRAP);
`else
    assign trap     = 1'b0;
`endif
endmodule
